n_output_port_ctrl: RTL

//  Output-port controller for the router's North output. Arbitrates North-bound packets

---
 rtl/n_output_port_ctrl_if.sv | 35 +++
 rtl/n_output_port_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/n_output_port_ctrl_if.sv
// Bundle of request, flit and credit signals between the North output-port controller
// and the input ports / crossbar / downstream credit logic.
interface n_output_port_ctrl_if #(
  parameter int unsigned CREDIT_W = 3
);
  logic [3:0]          req_i;
  logic [2:0]          s_nexthop_addr_i;
  logic [2:0]          w_nexthop_addr_i;
  logic [2:0]          e_nexthop_addr_i;
  logic [2:0]          l_nexthop_addr_i;
  logic [3:0]          flit_valid_i;
  logic [3:0]          flit_tail_i;
  logic                credit_return_i;
  logic [3:0]          grant_o;
  logic [2:0]          xbar_sel_o;
  logic                out_valid_o;
  logic                change_order_o;
  logic [CREDIT_W-1:0] credit_cnt_o;
  logic                timeout_err_o;
  logic                credit_err_o;

  modport master (
    output req_i, s_nexthop_addr_i, w_nexthop_addr_i, e_nexthop_addr_i, l_nexthop_addr_i,
    output flit_valid_i, flit_tail_i, credit_return_i,
    input  grant_o, xbar_sel_o, out_valid_o, change_order_o, credit_cnt_o,
    input  timeout_err_o, credit_err_o
  );

  modport slave (
    input  req_i, s_nexthop_addr_i, w_nexthop_addr_i, e_nexthop_addr_i, l_nexthop_addr_i,
    input  flit_valid_i, flit_tail_i, credit_return_i,
    output grant_o, xbar_sel_o, out_valid_o, change_order_o, credit_cnt_o,
    output timeout_err_o, credit_err_o
  );
endinterface

// File: rtl/n_output_port_ctrl.sv
// North output-port controller: round-robin packet arbitration over S/W/E/L, per-packet
// grant hold, downstream credit tracking and a stall timeout that forces release.
module n_output_port_ctrl #(
  parameter logic [2:0]  N_DIR_CODE   = 3'b001,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CREDIT_W     = 3,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic                clk,
  input logic                reset,
  n_output_port_ctrl_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [2:0]          sel_q, sel_d;
  logic [1:0]          gidx_q, gidx_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                co_q, co_d;
  logic                terr_q, terr_d;
  logic                cerr_q, cerr_d;

  logic [3:0] desire;
  logic       found;
  logic [1:0] pick;
  logic [1:0] scan_idx;
  logic       credit_ok;
  logic       xfer;
  logic       release_pkt;

  // Port order index 0..3 = S,W,E,L maps to vector bit ~idx ({S,W,E,L} = [3:0]).
  always_comb begin
    desire[3] = bus.req_i[3] && (bus.s_nexthop_addr_i == N_DIR_CODE);
    desire[2] = bus.req_i[2] && (bus.w_nexthop_addr_i == N_DIR_CODE);
    desire[1] = bus.req_i[1] && (bus.e_nexthop_addr_i == N_DIR_CODE);
    desire[0] = bus.req_i[0] && (bus.l_nexthop_addr_i == N_DIR_CODE);
  end

  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!found && desire[~scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign credit_ok = (credit_q != '0);
  assign xfer      = (state_q == StBusy) && bus.flit_valid_i[~gidx_q] && credit_ok;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_d       = tmo_q;
    co_d        = 1'b0;
    terr_d      = terr_q;
    release_pkt = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found && credit_ok) begin
          state_d = StBusy;
          gidx_d  = pick;
          grant_d = 4'b1000 >> pick;
          sel_d   = {1'b0, pick} + 3'd1;
          tmo_d   = '0;
        end
      end
      StBusy: begin
        if (xfer) begin
          tmo_d       = '0;
          release_pkt = bus.flit_tail_i[~gidx_q];
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          release_pkt = 1'b1;
          terr_d      = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
        if (release_pkt) begin
          state_d  = StIdle;
          grant_d  = '0;
          sel_d    = '0;
          co_d     = 1'b1;
          rr_ptr_d = gidx_q + 2'd1;
        end
      end
    endcase
  end

  // A return at full count with no transfer would overflow: saturate and flag.
  always_comb begin
    credit_d = credit_q;
    cerr_d   = cerr_q;
    if (xfer && !bus.credit_return_i) begin
      credit_d = credit_q - CREDIT_W'(1);
    end else if (!xfer && bus.credit_return_i) begin
      if (credit_q == CREDIT_W'(CREDIT_DEPTH)) begin
        cerr_d = 1'b1;
      end else begin
        credit_d = credit_q + CREDIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      sel_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      credit_q <= CREDIT_W'(CREDIT_DEPTH);
      tmo_q    <= '0;
      co_q     <= 1'b0;
      terr_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      co_q     <= co_d;
      terr_q   <= terr_d;
      cerr_q   <= cerr_d;
    end
  end

  assign bus.grant_o        = grant_q;
  assign bus.xbar_sel_o     = sel_q;
  assign bus.out_valid_o    = xfer;
  assign bus.change_order_o = co_q;
  assign bus.credit_cnt_o   = credit_q;
  assign bus.timeout_err_o  = terr_q;
  assign bus.credit_err_o   = cerr_q;

endmodule
